tl_rx_fc_dllp_gen: RTL and testbench

// - Sits between the RX flow-control block and the DLL transmit arbiter.
// - Consumes per-type credit reports (P/NP/CPL), coalesces them into one pending slot per type and formats 32-bit FC DLLPs (InitFC1/InitFC2/UpdateFC, VC0).
// - Issues them over a valid/ready handshake.
// - A periodic timer re-sends all known credit values in normal phase.

---
 rtl/tl_rx_fc_dllp_gen.sv | 129 ++++++++++++
 tb/tb_tl_rx_fc_dllp_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_rx_fc_dllp_gen.sv
//------------------------------------------------------------------------------
// tl_rx_fc_dllp_gen : coalesces P/NP/CPL credit reports and issues VC0 FC DLLPs
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tl_rx_fc_dllp_gen #(
  parameter int HDR_FIELD_SIZE      = 8,
  parameter int DATA_FIELD_SIZE     = 12,
  parameter int UPDATE_TIMER_CYCLES = 1000
) (
  input  logic                       i_clk,
  input  logic                       i_n_rst,
  input  logic [HDR_FIELD_SIZE-1:0]  i_fc_hdr_creds,
  input  logic [DATA_FIELD_SIZE-1:0] i_fc_data_creds,
  input  logic [1:0]                 i_fc_hdr_scale,
  input  logic [1:0]                 i_fc_data_scale,
  input  logic [1:0]                 i_fc_type,
  input  logic                       i_fc_creds_valid,
  input  logic [1:0]                 i_fc_phase,
  output logic [31:0]                o_dllp_data,
  output logic                       o_dllp_valid,
  input  logic                       i_dllp_ready,
  output logic [2:0]                 o_pending
);

  localparam int TW = $clog2(UPDATE_TIMER_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(UPDATE_TIMER_CYCLES - 1);

  logic [HDR_FIELD_SIZE-1:0]  hdr_q   [3];
  logic [DATA_FIELD_SIZE-1:0] data_q  [3];
  logic [1:0]                 hscale_q[3];
  logic [1:0]                 dscale_q[3];
  logic [2:0]                 pending;
  logic [2:0]                 pending_nxt;
  logic [2:0]                 known;
  logic [1:0]                 rr_ptr;
  logic [1:0]                 prev_phase;
  logic [TW-1:0]              timer;

  logic       report_hit;
  logic       load_en;
  logic       timer_fire;
  logic [1:0] ord1;
  logic [1:0] ord2;
  logic [1:0] win;
  logic [1:0] phase_code;
  logic [7:0] byte0;

  assign report_hit = i_fc_creds_valid && (i_fc_type != 2'b11);
  assign load_en    = (!o_dllp_valid || i_dllp_ready) && (|pending);
  assign timer_fire = i_fc_phase[1] && (i_fc_phase == prev_phase) && (timer == TIMER_LAST);

  // Search order starts at rr_ptr and wraps P -> NP -> CPL -> P.
  always_comb begin
    ord1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    ord2 = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
    if (pending[rr_ptr])    win = rr_ptr;
    else if (pending[ord1]) win = ord1;
    else                    win = ord2;
  end

  always_comb begin
    phase_code = 2'b01;
    if (i_fc_phase[1])      phase_code = 2'b10;
    else if (i_fc_phase[0]) phase_code = 2'b11;
    byte0 = {phase_code, win, 4'b0000};
  end

  // A report landing on the slot being loaded keeps it pending for the newer value.
  always_comb begin
    pending_nxt = pending;
    if (load_en)    pending_nxt[win] = 1'b0;
    if (timer_fire) pending_nxt = pending_nxt | known;
    if (report_hit) pending_nxt[i_fc_type] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      for (int i = 0; i < 3; i++) begin
        hdr_q[i]    <= '0;
        data_q[i]   <= '0;
        hscale_q[i] <= '0;
        dscale_q[i] <= '0;
      end
      pending <= '0;
      known   <= '0;
    end else begin
      pending <= pending_nxt;
      if (report_hit) begin
        hdr_q[i_fc_type]    <= i_fc_hdr_creds;
        data_q[i_fc_type]   <= i_fc_data_creds;
        hscale_q[i_fc_type] <= i_fc_hdr_scale;
        dscale_q[i_fc_type] <= i_fc_data_scale;
        known[i_fc_type]    <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      o_dllp_data  <= '0;
      o_dllp_valid <= 1'b0;
      rr_ptr       <= 2'd0;
    end else if (load_en) begin
      o_dllp_data  <= {byte0, hscale_q[win], hdr_q[win], dscale_q[win], data_q[win]};
      o_dllp_valid <= 1'b1;
      rr_ptr       <= (win == 2'd2) ? 2'd0 : win + 2'd1;
    end else if (i_dllp_ready) begin
      o_dllp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      timer      <= '0;
      prev_phase <= 2'b00;
    end else begin
      prev_phase <= i_fc_phase;
      if (!i_fc_phase[1] || (i_fc_phase != prev_phase) || (timer == TIMER_LAST)) timer <= '0;
      else                                                                         timer <= timer + 1'b1;
    end
  end

  assign o_pending = pending;

endmodule

`default_nettype wire

// File: tb/tb_tl_rx_fc_dllp_gen.sv
//------------------------------------------------------------------------------
// tb_tl_rx_fc_dllp_gen : scoreboard bench with a slot-level reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tl_rx_fc_dllp_gen;

  localparam int UPD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  hdr;
  logic [11:0] data;
  logic [1:0]  hs, ds, ftype, phase;
  logic        cv, ready;
  logic [31:0] dllp_data;
  logic        dllp_valid;
  logic [2:0]  pend;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got[$];

  // reference model state
  logic [7:0]  m_hdr[3];
  logic [11:0] m_data[3];
  logic [1:0]  m_hs[3], m_ds[3];
  bit          m_pend[3], m_known[3];
  bit          m_valid;
  int          m_next, m_t;
  logic [1:0]  m_prev;

  tl_rx_fc_dllp_gen #(
    .HDR_FIELD_SIZE(8), .DATA_FIELD_SIZE(12), .UPDATE_TIMER_CYCLES(UPD)
  ) dut (
    .i_clk(clk), .i_n_rst(rst_n),
    .i_fc_hdr_creds(hdr), .i_fc_data_creds(data),
    .i_fc_hdr_scale(hs), .i_fc_data_scale(ds),
    .i_fc_type(ftype), .i_fc_creds_valid(cv), .i_fc_phase(phase),
    .o_dllp_data(dllp_data), .o_dllp_valid(dllp_valid),
    .i_dllp_ready(ready), .o_pending(pend)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] fmt(int t, logic [1:0] ph);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] h;
    logic [11:0] d;
    h  = m_hdr[t];
    d  = m_data[t];
    b0 = (ph >= 2'd2) ? 8'h80 : (ph == 2'd1) ? 8'hC0 : 8'h40;
    b0 = b0 | 8'(t << 4);
    b1 = {m_hs[t], h[7:2]};
    b2 = {h[1:0], m_ds[t], d[11:8]};
    b3 = d[7:0];
    return {b0, b1, b2, b3};
  endfunction

  // Reference model: one coalescing slot per type, round-robin drain, periodic refresh.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_hdr[i] = 0; m_data[i] = 0; m_hs[i] = 0; m_ds[i] = 0;
        m_pend[i] = 0; m_known[i] = 0;
      end
      m_valid = 0; m_next = 0; m_t = 0; m_prev = 2'b00;
      exp_q.delete();
    end else begin
      bit any;
      any = m_pend[0] || m_pend[1] || m_pend[2];
      if ((!m_valid || ready) && any) begin
        int w;
        w = -1;
        for (int k = 0; k < 3; k++)
          if (w < 0 && m_pend[(m_next + k) % 3]) w = (m_next + k) % 3;
        exp_q.push_back(fmt(w, phase));
        m_valid = 1; m_pend[w] = 0; m_next = (w + 1) % 3;
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
      if (phase != m_prev) m_t = 0;
      else if (phase >= 2'd2) begin
        if (m_t == UPD - 1) begin
          m_t = 0;
          for (int i = 0; i < 3; i++) if (m_known[i]) m_pend[i] = 1;
        end else m_t++;
      end else m_t = 0;
      m_prev = phase;
      if (cv && ftype != 2'b11) begin
        m_hdr[ftype] = hdr; m_data[ftype] = data;
        m_hs[ftype] = hs; m_ds[ftype] = ds;
        m_pend[ftype] = 1; m_known[ftype] = 1;
      end
    end
  end

  // Monitor: compares handshake state and presented data against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("valid", 32'(dllp_valid), 32'(m_valid));
      chk("pending", 32'(pend), 32'({m_pend[2], m_pend[1], m_pend[0]}));
      if (dllp_valid) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL dllp_unexpected: got %h expected none at %0t", dllp_data, $time);
        end else begin
          chk("dllp_data", dllp_data, exp_q[0]);
          if (ready) begin
            got.push_back(dllp_data);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(2); rst_n = 1'b1;
  endtask

  task automatic report(logic [1:0] t, logic [7:0] h, logic [11:0] d, logic [1:0] s1, logic [1:0] s2);
    ftype = t; hdr = h; data = d; hs = s1; ds = s2; cv = 1'b1;
    cyc(1);
    cv = 1'b0;
  endtask

  initial begin
    logic [31:0] g;
    int nonp;
    rst_n = 1'b0; cv = 0; ftype = 0; hdr = 0; data = 0; hs = 0; ds = 0;
    phase = 2'b10; ready = 0;
    cyc(2);
    chk("rst_valid", 32'(dllp_valid), 0);
    chk("rst_pending", 32'(pend), 0);
    chk("rst_data", dllp_data, 0);
    rst_n = 1'b1;
    cyc(1);

    // normal-phase single P report, latency N+2 and hold
    report(2'd0, 8'h25, 12'h3A7, 2'd0, 2'd0);
    chk("lat_n1_valid", 32'(dllp_valid), 0);
    cyc(1);
    chk("lat_n2_valid", 32'(dllp_valid), 1);
    chk("lat_n2_data", dllp_data, 32'h800943A7);
    cyc(4);
    chk("hold_valid", 32'(dllp_valid), 1);
    chk("hold_data", dllp_data, 32'h800943A7);
    ready = 1; cyc(3); ready = 0;

    // InitFC1 P, NP, CPL back-to-back
    do_reset(); phase = 2'b00; ready = 1; got.delete();
    report(2'd0, 8'h11, 12'h111, 2'd1, 2'd2);
    report(2'd1, 8'h22, 12'h222, 2'd2, 2'd3);
    report(2'd2, 8'h33, 12'h333, 2'd3, 2'd1);
    cyc(8);
    chk("b2b_count", 32'(got.size()), 3);
    if (got.size() == 3) begin
      g = got[0]; chk("b2b_p",   32'(g[31:24]), 32'h40);
      g = got[1]; chk("b2b_np",  32'(g[31:24]), 32'h50);
      g = got[2]; chk("b2b_cpl", 32'(g[31:24]), 32'h60);
    end

    // NP overwrite while stalled
    do_reset(); phase = 2'b01; ready = 0; got.delete();
    report(2'd1, 8'h05, 12'h010, 2'd0, 2'd0);
    report(2'd1, 8'h05, 12'h020, 2'd0, 2'd0);
    cyc(3); ready = 1; cyc(6);
    chk("ovr_count", 32'(got.size()), 2);
    if (got.size() == 2) begin
      g = got[0]; chk("ovr_first",  32'(g[11:0]), 32'h010);
      g = got[1]; chk("ovr_second", 32'(g[11:0]), 32'h020);
      chk("ovr_byte0", 32'(g[31:24]), 32'hD0);
    end

    // round-robin after NP was last sent
    do_reset(); phase = 2'b00; ready = 0; got.delete();
    report(2'd1, 8'h01, 12'h001, 2'd0, 2'd0);
    report(2'd0, 8'h02, 12'h002, 2'd0, 2'd0);
    report(2'd1, 8'h03, 12'h003, 2'd0, 2'd0);
    report(2'd2, 8'h04, 12'h004, 2'd0, 2'd0);
    cyc(1); ready = 1; cyc(10);
    chk("rr_count", 32'(got.size()), 4);
    if (got.size() == 4) begin
      g = got[1]; chk("rr_1st_cpl", 32'(g[31:24]), 32'h60);
      g = got[2]; chk("rr_2nd_p",   32'(g[31:24]), 32'h40);
      g = got[3]; chk("rr_3rd_np",  32'(g[31:24]), 32'h50);
    end

    // periodic refresh of the only known slot
    do_reset(); phase = 2'b10; ready = 1; got.delete();
    report(2'd0, 8'h7F, 12'hABC, 2'd1, 2'd1);
    cyc(60);
    nonp = 0;
    foreach (got[k]) begin g = got[k]; if (g[29:28] != 2'b00) nonp++; end
    chk("timer_nonp", 32'(nonp), 0);
    chk("timer_enough", 32'(got.size() >= 6), 1);

    // async reset mid-handshake
    do_reset(); phase = 2'b00; ready = 0;
    report(2'd0, 8'h10, 12'h100, 2'd0, 2'd0);
    report(2'd1, 8'h20, 12'h200, 2'd0, 2'd0);
    cyc(2);
    chk("ar_pre_valid", 32'(dllp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(dllp_valid), 0);
    chk("ar_pending", 32'(pend), 0);
    cyc(2); rst_n = 1'b1; ready = 1; got.delete();
    cyc(10);
    chk("ar_no_output", 32'(got.size()), 0);

    // randomized traffic
    do_reset(); phase = 2'b10;
    for (int i = 0; i < 3000; i++) begin
      cv    = (i < 1500) ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
      ftype = 2'($urandom % 4);
      hdr   = 8'($urandom);
      data  = 12'($urandom);
      hs    = 2'($urandom);
      ds    = 2'($urandom);
      ready = ($urandom % 4 != 0);
      if ($urandom % 200 == 0) phase = 2'($urandom % 3);
      cyc(1);
    end
    cv = 0; ready = 1; phase = 2'b00;
    cyc(20);
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
